// File: rtl/id_stage.sv
// Instruction-decode stage: register file with write-through bypass, main control
// decoder, sign-extender and load-use hazard detection feeding the ID/EX register.
module id_stage #(
  parameter int REG_COUNT = 32,
  parameter int PC_WIDTH  = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         instruction,
  input  logic [PC_WIDTH-1:0] pcIn,
  input  logic                regWriteIn,
  input  logic [4:0]          writeRegister,
  input  logic [31:0]         writeData,
  input  logic                idExMemRead,
  input  logic [4:0]          idExRegisterTarget,
  input  logic                flush,
  output logic [1:0]          writeBackOut,
  output logic [2:0]          memoryOut,
  output logic [3:0]          EX,
  output logic [PC_WIDTH-1:0] pcOut,
  output logic [31:0]         register1Out,
  output logic [31:0]         register2Out,
  output logic [31:0]         offsetOut,
  output logic [4:0]          registerTargetOut,
  output logic [4:0]          registerDestinationOut,
  output logic                stall,
  output logic                pcWrite,
  output logic                ifIdWrite
);

  logic [31:0] regs [REG_COUNT];

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       hazard;
  logic       bubble;
  logic [8:0] ctrl;  // {EX[3:0], WB[1:0], MEM[2:0]}

  assign opcode = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (regWriteIn && writeRegister != 5'd0) begin
      regs[writeRegister] <= writeData;
    end
  end

  // Write-then-read: a same-cycle WB write to the addressed register wins.
  function automatic logic [31:0] read_port(input logic [4:0] addr);
    if (reset || addr == 5'd0) begin
      return 32'd0;
    end else if (regWriteIn && writeRegister == addr) begin
      return writeData;
    end else begin
      return regs[addr];
    end
  endfunction

  always_comb begin
    register1Out = read_port(rs);
    register2Out = read_port(rt);
  end

  always_comb begin
    ctrl = 9'b0000_00_000;
    unique case (opcode)
      6'b000000: ctrl = 9'b1100_10_000;
      6'b100011: ctrl = 9'b0001_11_010;
      6'b101011: ctrl = 9'b0001_00_001;
      6'b000100: ctrl = 9'b0010_00_100;
      6'b001000: ctrl = 9'b0001_10_000;
      default:   ctrl = 9'b0000_00_000;
    endcase
  end

  assign hazard = idExMemRead && (idExRegisterTarget != 5'd0) &&
                  (idExRegisterTarget == rs || idExRegisterTarget == rt);
  assign bubble = hazard || flush || reset;

  assign stall     = hazard && !reset;
  assign pcWrite   = !stall;
  assign ifIdWrite = !stall;

  assign EX           = bubble ? 4'd0 : ctrl[8:5];
  assign writeBackOut = bubble ? 2'd0 : ctrl[4:3];
  assign memoryOut    = bubble ? 3'd0 : ctrl[2:0];

  assign pcOut                  = pcIn;
  assign offsetOut              = {{16{instruction[15]}}, instruction[15:0]};
  assign registerTargetOut      = rt;
  assign registerDestinationOut = rd;

endmodule
